layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised, pipelined pixel colour compositor between the sprite/object generators and the VGA output path.
- Merges NUM_LAYERS sprite layers by fixed priority over a mode-dependent banner and a black background.
- Tracks the game screen mode (START/PLAY/OVER) with a blinking start banner and a frame-stepped fade-out/fade-in on mode change.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; a higher index has higher priority.
- COLOR_W, 8, bits per colour channel.
- BANNER_X0, 280, banner left edge (inclusive).
- BANNER_X1, 360, banner right edge (exclusive).
- BANNER_Y0, 208, banner top edge (inclusive).
- BANNER_Y1, 272, banner bottom edge (exclusive).
- BLINK_FRAMES, 30, frames per START-banner on/off half-period.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- screen_mode  in  2  requested mode: 0=START, 1=PLAY, 2=OVER; 3 is treated as PLAY.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  per-layer {R,G,B}; layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W].
- Red  out  COLOR_W  composited red.
- Green  out  COLOR_W  composited green.
- Blue  out  COLOR_W  composited blue.
- active_mode  out  2  mode currently displayed.
- fade_busy  out  1  high while a fade is in progress.

Behaviour:
- Reset (async): Red/Green/Blue=0, active_mode=START, target_mode=START, fade level=0, FSM=IDLE, blink counter=0, blink phase=on, all pipeline registers=0.
- Latency: exactly 2 Clk cycles from DrawX/DrawY/layer_on/layer_rgb to RGB. Fully pipelined, one pixel per cycle, no stalls.
- Stage 1 registers the winning colour:
  - The highest-index i with layer_on[i]=1 wins.
  - Otherwise, if banner_hit, the banner colour wins: START with blink phase on gives all-ones white; OVER gives {all-ones,0,0} red; PLAY has no banner.
  - Otherwise the colour is black.
  - banner_hit = BANNER_X0<=DrawX<BANNER_X1 and BANNER_Y0<=DrawY<BANNER_Y1, using unsigned compares.
- Stage 2 registers each channel right-shifted by the fade level (0..COLOR_W). At level COLOR_W the output is 0.
- Blink:
  - The counter increments on frame_start while active_mode=START.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - Entering START clears the counter and sets phase=on.
- Fade FSM (states IDLE, FADE_OUT, FADE_IN). Let req = screen_mode, with 3 mapped to PLAY.
  - IDLE: if req != target_mode, set target_mode=req and go to FADE_OUT.
  - FADE_OUT: on frame_start, level++. When the new level equals COLOR_W, set active_mode=target_mode and go to FADE_IN. A req change updates target_mode without restarting.
  - FADE_IN: on frame_start, level--. When the new level equals 0, go to IDLE. If req != target_mode, set target_mode=req and return to FADE_OUT; the level continues upward from its current value.
  - A mode change and frame_start in the same cycle in IDLE: the transition happens, and the level is not stepped that cycle.
  - fade_busy = (state != IDLE).
- A mid-operation Reset returns every register to its reset value immediately; outputs read 0 from the next edge onward.

Optional Feature:
- Macro: COMPOSITOR_FADE_EN.
- Defined: fade FSM and level as described above.
- Undefined:
  - No FSM; level is constant 0 and fade_busy is tied 0.
  - active_mode and target_mode take req on the next Clk edge after any change.
  - Latency stays 2 cycles and the stage-2 register remains.

Test Plan:
- After reset, active_mode=START, all layer_on=0, DrawX=300, DrawY=240 -> RGB=FFFFFF 2 cycles later. DrawX=360 -> 000000.
- layer_on=4'b1010, layer1=00FF00, layer3=FF0000, PLAY settled -> RGB=FF0000. layer_on=4'b0010 -> 00FF00.
- START, banner pixel held, 30 frame_start pulses -> 000000 after the 30th. After 30 more -> FFFFFF.
- START to PLAY with fade enabled, layer0=FFFFFF on -> level steps 1..8 over 8 frames (RGB 7F7F7F, 3F3F3F, ... 000000). active_mode=PLAY at the 8th pulse, then RGB returns to FFFFFF after 8 more pulses; fade_busy falls then.
- Request OVER during FADE_IN at level 5 -> FADE_OUT resumes: 6, 7, 8. Then active_mode=OVER; a banner pixel yields FF0000 once level=0.
- Assert Reset mid-fade at level 4 -> next sample shows RGB=0, fade_busy=0, active_mode=START. With the macro undefined, a mode change updates active_mode one cycle later.

Source files
------------

// File: rtl/layer_compositor_if.sv
// Pixel-side bundle for layer_compositor: frame timing, mode request, raster
// position, per-layer sprite hits/colours in; composited RGB and mode status out.
interface layer_compositor_if #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned COLOR_W    = 8
);
   logic                              frame_start;
   logic [1:0]                        screen_mode;
   logic [9:0]                        DrawX;
   logic [9:0]                        DrawY;
   logic [NUM_LAYERS-1:0]             layer_on;
   logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
   logic [COLOR_W-1:0]                Red;
   logic [COLOR_W-1:0]                Green;
   logic [COLOR_W-1:0]                Blue;
   logic [1:0]                        active_mode;
   logic                              fade_busy;

   modport master (
      output frame_start, screen_mode, DrawX, DrawY, layer_on, layer_rgb,
      input  Red, Green, Blue, active_mode, fade_busy
   );

   modport slave (
      input  frame_start, screen_mode, DrawX, DrawY, layer_on, layer_rgb,
      output Red, Green, Blue, active_mode, fade_busy
   );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage priority compositor (sprites > banner > black) with blinking START banner.
// Define COMPOSITOR_FADE_EN for the frame-stepped fade-out/fade-in on mode change.
module layer_compositor #(
   parameter int unsigned NUM_LAYERS   = 4,
   parameter int unsigned COLOR_W      = 8,
   parameter int unsigned BANNER_X0    = 280,
   parameter int unsigned BANNER_X1    = 360,
   parameter int unsigned BANNER_Y0    = 208,
   parameter int unsigned BANNER_Y1    = 272,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic             Clk,
   input  logic             Reset,
   layer_compositor_if.slave bus
);
   localparam int unsigned PIX_W = 3 * COLOR_W;
   localparam int unsigned LVL_W = $clog2(COLOR_W + 1);
   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [9:0]       BX0      = 10'(BANNER_X0);
   localparam logic [9:0]       BX1      = 10'(BANNER_X1);
   localparam logic [9:0]       BY0      = 10'(BANNER_Y0);
   localparam logic [9:0]       BY1      = 10'(BANNER_Y1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      MODE_START = 2'd0,
      MODE_PLAY  = 2'd1,
      MODE_OVER  = 2'd2
   } mode_t;

   mode_t              w_req;
   mode_t              r_active;
   mode_t              w_active_next;
   logic [LVL_W-1:0]   w_level;
   logic               w_fade_busy;
   logic               w_enter_start;
   logic               w_banner_hit;
   logic [CNT_W-1:0]   r_blink_cnt;
   logic               r_blink_on;
   logic [PIX_W-1:0]   w_s1;
   logic [PIX_W-1:0]   r_s1;
   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_grn;
   logic [COLOR_W-1:0] r_blu;

   assign w_req = (bus.screen_mode == 2'd3) ? MODE_PLAY : mode_t'(bus.screen_mode);

`ifdef COMPOSITOR_FADE_EN
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(COLOR_W);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_FADE_IN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   mode_t            r_target;
   mode_t            w_target_next;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_next;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_target <= MODE_START;
         r_level  <= '0;
      end else begin
         r_state  <= w_state_next;
         r_target <= w_target_next;
         r_level  <= w_level_next;
      end
   end

   // A request change in FADE_IN turns the fade around without stepping that cycle.
   always_comb begin
      w_state_next  = r_state;
      w_target_next = r_target;
      w_level_next  = r_level;
      w_active_next = r_active;
      unique case (r_state)
         ST_IDLE: begin
            if (w_req != r_target) begin
               w_target_next = w_req;
               w_state_next  = ST_FADE_OUT;
            end
         end
         ST_FADE_OUT: begin
            w_target_next = w_req;
            if (bus.frame_start) begin
               w_level_next = r_level + 1'b1;
               if (w_level_next == LVL_MAX) begin
                  w_active_next = w_req;
                  w_state_next  = ST_FADE_IN;
               end
            end
         end
         ST_FADE_IN: begin
            if (w_req != r_target) begin
               w_target_next = w_req;
               w_state_next  = ST_FADE_OUT;
            end else if (bus.frame_start) begin
               w_level_next = r_level - 1'b1;
               if (w_level_next == '0) w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_level     = r_level;
   assign w_fade_busy = (r_state != ST_IDLE);
`else
   assign w_active_next = w_req;
   assign w_level       = '0;
   assign w_fade_busy   = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_active <= MODE_START;
      else       r_active <= w_active_next;
   end

   assign w_enter_start = (w_active_next == MODE_START) && (r_active != MODE_START);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (w_enter_start) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (bus.frame_start && (r_active == MODE_START)) begin
         if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign w_banner_hit = (bus.DrawX >= BX0) && (bus.DrawX < BX1) &&
                         (bus.DrawY >= BY0) && (bus.DrawY < BY1);

   // Ascending scan so the highest-index active layer overrides the rest.
   always_comb begin
      w_s1 = '0;
      if (w_banner_hit) begin
         if ((r_active == MODE_START) && r_blink_on) w_s1 = '1;
         else if (r_active == MODE_OVER) w_s1 = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
      end
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (bus.layer_on[i]) w_s1 = bus.layer_rgb[i*PIX_W +: PIX_W];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1  <= '0;
         r_red <= '0;
         r_grn <= '0;
         r_blu <= '0;
      end else begin
         r_s1  <= w_s1;
         r_red <= r_s1[PIX_W-1 -: COLOR_W] >> w_level;
         r_grn <= r_s1[2*COLOR_W-1 -: COLOR_W] >> w_level;
         r_blu <= r_s1[COLOR_W-1:0] >> w_level;
      end
   end

   assign bus.Red         = r_red;
   assign bus.Green       = r_grn;
   assign bus.Blue        = r_blu;
   assign bus.active_mode = r_active;
   assign bus.fade_busy   = w_fade_busy;
endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed literal checks plus random
// traffic compared every cycle against a frame/pixel-level model of the compositor.
module tb_layer_compositor;
   localparam int NL = 4;
   localparam int CW = 8;
   localparam int X0 = 280;
   localparam int X1 = 360;
   localparam int Y0 = 208;
   localparam int Y1 = 272;
   localparam int BF = 30;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

   layer_compositor #(
      .NUM_LAYERS(NL), .COLOR_W(CW),
      .BANNER_X0(X0), .BANNER_X1(X1), .BANNER_Y0(Y0), .BANNER_Y1(Y1),
      .BLINK_FRAMES(BF)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit m_go  = 1'b0;

   // Model state: displayed mode, requested mode, fade phase (0 idle, 1 out, 2 in),
   // fade level, blink counter/phase, and the two pixel pipeline slots.
   int          m_active, m_target, m_fade, m_level, m_cnt;
   bit          m_phase;
   logic [23:0] m_s1, m_out;

   function automatic logic [23:0] dim(input logic [23:0] p, input int l);
      logic [7:0] r, g, b;
      r = p[23:16] >> l;
      g = p[15:8] >> l;
      b = p[7:0] >> l;
      return {r, g, b};
   endfunction

   function automatic logic [23:0] white_dim(input int l);
      return dim(24'hFFFFFF, l);
   endfunction

   function automatic logic [23:0] pixel_colour();
      logic [23:0] c;
      int x, y;
      c = 24'h000000;
      x = int'(bus.DrawX);
      y = int'(bus.DrawY);
      if (x >= X0 && x < X1 && y >= Y0 && y < Y1) begin
         if (m_active == 0 && m_phase) c = 24'hFFFFFF;
         if (m_active == 2)            c = 24'hFF0000;
      end
      for (int i = NL - 1; i >= 0; i--) begin
         if (bus.layer_on[i]) begin
            c = bus.layer_rgb[i*24 +: 24];
            break;
         end
      end
      return c;
   endfunction

   task automatic model_reset();
      m_active = 0; m_target = 0; m_fade = 0; m_level = 0;
      m_cnt = 0; m_phase = 1'b1; m_s1 = '0; m_out = '0;
   endtask

   task automatic model_step();
      int req, na;
      logic [23:0] s1n, outn;
      bit fs;
      if (Reset) begin
         model_reset();
         return;
      end
      req  = (bus.screen_mode == 2'd3) ? 1 : int'(bus.screen_mode);
      fs   = bus.frame_start;
      s1n  = pixel_colour();
      outn = dim(m_s1, m_level);
      na   = m_active;
`ifdef COMPOSITOR_FADE_EN
      if (m_fade == 0) begin
         if (req != m_target) begin m_target = req; m_fade = 1; end
      end else if (m_fade == 1) begin
         m_target = req;
         if (fs) begin
            m_level++;
            if (m_level == CW) begin na = req; m_fade = 2; end
         end
      end else begin
         if (req != m_target) begin
            m_target = req; m_fade = 1;
         end else if (fs) begin
            m_level--;
            if (m_level == 0) m_fade = 0;
         end
      end
`else
      na = req;
      m_target = req;
`endif
      if (na == 0 && m_active != 0) begin
         m_cnt = 0; m_phase = 1'b1;
      end else if (fs && m_active == 0) begin
         if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
         else m_cnt++;
      end
      m_active = na;
      m_s1     = s1n;
      m_out    = outn;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk or posedge Reset);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (m_go) begin
            n_cmp++;
            if ({bus.Red, bus.Green, bus.Blue} !== m_out) begin
               n_bad++;
               $display("FAIL model_rgb t=%0t: got %h expected %h", $time,
                        {bus.Red, bus.Green, bus.Blue}, m_out);
            end
            n_cmp++;
            if (bus.active_mode !== 2'(m_active)) begin
               n_bad++;
               $display("FAIL model_mode t=%0t: got %0d expected %0d", $time, bus.active_mode, m_active);
            end
            n_cmp++;
            if (bus.fade_busy !== (m_fade != 0)) begin
               n_bad++;
               $display("FAIL model_busy t=%0t: got %0b expected %0b", $time, bus.fade_busy, (m_fade != 0));
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
      tick();
   endtask

   function automatic logic [23:0] rgb();
      return {bus.Red, bus.Green, bus.Blue};
   endfunction

   initial begin
      bus.frame_start = 1'b0;
      bus.screen_mode = 2'd0;
      bus.DrawX       = '0;
      bus.DrawY       = '0;
      bus.layer_on    = '0;
      bus.layer_rgb   = '0;
      #1 Reset = 1'b1;
      m_go = 1'b1;
      tick();
      chk("reset_rgb", 32'(rgb()), 32'h000000);
      chk("reset_mode", 32'(bus.active_mode), 32'd0);
      chk("reset_busy", 32'(bus.fade_busy), 32'd0);
      Reset = 1'b0;
      tick();

      bus.DrawX = 10'd300; bus.DrawY = 10'd240;
      tick(); tick();
      chk("start_banner", 32'(rgb()), 32'hFFFFFF);
      bus.DrawX = 10'd360;
      tick(); tick();
      chk("banner_x1_edge", 32'(rgb()), 32'h000000);
      bus.DrawX = 10'd279;
      tick(); tick();
      chk("banner_x0_minus1", 32'(rgb()), 32'h000000);
      bus.DrawX = 10'd300;

      repeat (29) frame();
      chk("blink_29", 32'(rgb()), 32'hFFFFFF);
      frame();
      chk("blink_30_off", 32'(rgb()), 32'h000000);
      repeat (30) frame();
      chk("blink_60_on", 32'(rgb()), 32'hFFFFFF);

      bus.layer_rgb = {24'hFF0000, 24'h000000, 24'h00FF00, 24'h000000};
      bus.layer_on  = 4'b1010;
      tick(); tick();
      chk("prio_l3", 32'(rgb()), 32'hFF0000);
      bus.layer_on  = 4'b0010;
      tick(); tick();
      chk("prio_l1", 32'(rgb()), 32'h00FF00);

`ifdef COMPOSITOR_FADE_EN
      bus.layer_rgb = {72'h0, 24'hFFFFFF};
      bus.layer_on  = 4'b0001;
      bus.screen_mode = 2'd1;
      tick(); tick(); tick();
      chk("fade_start_busy", 32'(bus.fade_busy), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         frame();
         chk("fade_out_lvl", 32'(rgb()), 32'(white_dim(k)));
      end
      chk("fade_mode_play", 32'(bus.active_mode), 32'd1);
      for (int k = 7; k >= 0; k--) begin
         frame();
         chk("fade_in_lvl", 32'(rgb()), 32'(white_dim(k)));
      end
      chk("fade_done_busy", 32'(bus.fade_busy), 32'd0);

      bus.screen_mode = 2'd0;
      tick();
      repeat (8) frame();
      chk("back_to_start", 32'(bus.active_mode), 32'd0);
      repeat (3) frame();
      chk("fade_in_lvl5", 32'(rgb()), 32'(white_dim(5)));
      bus.screen_mode = 2'd2;
      tick();
      for (int k = 6; k <= 8; k++) begin
         frame();
         chk("resume_out_lvl", 32'(rgb()), 32'(white_dim(k)));
      end
      chk("over_mode", 32'(bus.active_mode), 32'd2);
      repeat (8) frame();
      bus.layer_on = '0;
      tick(); tick();
      chk("over_banner", 32'(rgb()), 32'hFF0000);

      bus.screen_mode = 2'd1;
      tick();
      repeat (4) frame();
      chk("mid_fade_lvl4", 32'(rgb()), 32'h0F0000);
      Reset = 1'b1;
      tick();
      chk("midreset_rgb", 32'(rgb()), 32'h000000);
      chk("midreset_busy", 32'(bus.fade_busy), 32'd0);
      chk("midreset_mode", 32'(bus.active_mode), 32'd0);
      bus.screen_mode = 2'd0;
      Reset = 1'b0;
      tick();
`else
      bus.layer_on  = 4'b1010;
      bus.screen_mode = 2'd1;
      tick();
      chk("nofade_mode_play", 32'(bus.active_mode), 32'd1);
      tick();
      chk("nofade_prio", 32'(rgb()), 32'hFF0000);
      bus.screen_mode = 2'd3;
      tick();
      chk("mode3_is_play", 32'(bus.active_mode), 32'd1);
      bus.screen_mode = 2'd2;
      bus.layer_on = '0;
      tick();
      chk("nofade_mode_over", 32'(bus.active_mode), 32'd2);
      tick(); tick();
      chk("over_banner", 32'(rgb()), 32'hFF0000);
      chk("nofade_busy", 32'(bus.fade_busy), 32'd0);
      Reset = 1'b1;
      tick();
      chk("midreset_rgb", 32'(rgb()), 32'h000000);
      chk("midreset_mode", 32'(bus.active_mode), 32'd0);
      bus.screen_mode = 2'd0;
      Reset = 1'b0;
      tick();
`endif

      for (int c = 0; c < 4000; c++) begin
         bus.DrawX = 10'($urandom_range(260, 380));
         bus.DrawY = 10'($urandom_range(190, 290));
         for (int i = 0; i < NL; i++) bus.layer_on[i] = ($urandom_range(0, 3) == 0);
         bus.layer_rgb = {$urandom, $urandom, $urandom};
         bus.frame_start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) bus.screen_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1499) == 0) Reset = 1'b1;
         tick();
         Reset = 1'b0;
      end
      bus.frame_start = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion expected finish before 2ms");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end
endmodule
